// File: rtl/ddr_serialiser.sv
// ----------------------------------------------------------------------------
// ddr_serialiser
//
// Purpose:
//   Turns a stream of W-bit parallel words into two bits per clock
//   (d_rise, d_fall) for the DDR output pad stage. That stage emits d_rise
//   in the high half of clk and d_fall in the low half.
//
//   A one-word holding buffer sits in front of the shift register. The next
//   word can therefore be captured while the current word is still being
//   shifted out. Words stream without gaps at W/2 clocks per word, as long
//   as the producer keeps up. While nothing is being shifted, both outputs
//   sit at IDLE_LEVEL.
//
// Parameters:
//   W          word width; even, >= 2
//   MSB_FIRST  1: bit W-1 goes out first (on d_rise); 0: bit 0 goes out first
//   IDLE_LEVEL level driven on d_rise/d_fall while the shifter is idle
//
// Ports:
//   clk       clock; also clocks the DDR output stage
//   rst_n     asynchronous, active-low reset
//   in_data   word to serialise
//   in_valid  in_data is valid
//   in_ready  word is taken on a rising edge where in_valid && in_ready
//   d_rise    bit for the next rising-edge half-cycle
//   d_fall    bit for the following falling-edge half-cycle
//   active    shift register holds a word that is being sent
//   underrun  one-cycle pulse: the shifter went idle because no word was held
// ----------------------------------------------------------------------------
module ddr_serialiser #(
    parameter int unsigned W          = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         d_rise,
    output logic         d_fall,
    output logic         active,
    output logic         underrun
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int unsigned HALF_W = W / 2;
    // The pair counter needs at least one bit, even when a word is a single pair.
    localparam int unsigned CNT_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [W-1:0]     WORD_ZERO = {W{1'b0}};

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [W-1:0]     hold_r;
    logic             hold_valid_r;
    logic [W-1:0]     sr_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic             underrun_r;

    // ------------------------------------------------------------------------
    // Next-state values and decoded control
    // ------------------------------------------------------------------------
    logic [W-1:0]     hold_nxt_s;
    logic             hold_valid_nxt_s;
    logic [W-1:0]     sr_nxt_s;
    logic             busy_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             underrun_nxt_s;

    logic             last_s;      // shifter is presenting the final pair of its word
    logic             load_s;      // held word moves into the shifter this edge
    logic             accept_s;    // producer handshake completes this edge
    logic             in_ready_s;
    logic [W-1:0]     sr_shift_s;  // shift register advanced by one pair

    // ------------------------------------------------------------------------
    // Pair shift.
    // The bits already sent are dropped at the output end and zeros are
    // filled in at the other end. For W == 2 a word is a single pair, so
    // advancing by one pair always empties the register.
    // ------------------------------------------------------------------------
    generate
        if (W == 2) begin : g_shift_single_pair
            assign sr_shift_s = WORD_ZERO;
        end else if (MSB_FIRST) begin : g_shift_msb
            assign sr_shift_s = {sr_r[W-3:0], 2'b00};
        end else begin : g_shift_lsb
            assign sr_shift_s = {2'b00, sr_r[W-1:2]};
        end
    endgenerate

    // Control decode. This logic looks only at registered state, so in_ready
    // never depends on in_valid and there is no combinational handshake loop.
    always_comb begin
        last_s     = busy_r && (cnt_r == CNT_LAST);
        load_s     = hold_valid_r && (!busy_r || last_s);
        in_ready_s = !hold_valid_r || load_s;
        accept_s   = in_valid && in_ready_s;
    end

    // State register: async reset discards any partial word and any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r       <= WORD_ZERO;
            hold_valid_r <= 1'b0;
            sr_r         <= WORD_ZERO;
            busy_r       <= 1'b0;
            cnt_r        <= CNT_ZERO;
            underrun_r   <= 1'b0;
        end else begin
            hold_r       <= hold_nxt_s;
            hold_valid_r <= hold_valid_nxt_s;
            sr_r         <= sr_nxt_s;
            busy_r       <= busy_nxt_s;
            cnt_r        <= cnt_nxt_s;
            underrun_r   <= underrun_nxt_s;
        end
    end

    // Next-state logic for the shifter, the holding buffer and the underrun flag.
    always_comb begin
        // Shifter: a load takes priority. When the last pair of a word is
        // shown and a word is held, that word takes over on the very next
        // cycle. This is what removes any gap between words.
        sr_nxt_s   = sr_r;
        busy_nxt_s = busy_r;
        cnt_nxt_s  = cnt_r;
        if (load_s) begin
            sr_nxt_s   = hold_r;
            cnt_nxt_s  = CNT_ZERO;
            busy_nxt_s = 1'b1;
        end else if (busy_r) begin
            sr_nxt_s  = sr_shift_s;
            cnt_nxt_s = cnt_r + CNT_ONE;
            if (last_s) begin
                busy_nxt_s = 1'b0;
            end else begin
                busy_nxt_s = 1'b1;
            end
        end else begin
            sr_nxt_s   = sr_r;
            cnt_nxt_s  = cnt_r;
            busy_nxt_s = 1'b0;
        end

        // Holding buffer. When a word is accepted in the same edge as a load,
        // the new word overwrites the one that just moved into the shifter,
        // so hold_valid stays set.
        hold_nxt_s       = hold_r;
        hold_valid_nxt_s = hold_valid_r;
        if (accept_s) begin
            hold_nxt_s       = in_data;
            hold_valid_nxt_s = 1'b1;
        end else if (load_s) begin
            hold_nxt_s       = hold_r;
            hold_valid_nxt_s = 1'b0;
        end else begin
            hold_nxt_s       = hold_r;
            hold_valid_nxt_s = hold_valid_r;
        end

        // The shifter is about to fall idle with nothing waiting to replace it.
        underrun_nxt_s = last_s && !hold_valid_r;
    end

    // Output decode. Every output comes from registered state; nothing passes
    // straight from an input to an output.
    always_comb begin
        in_ready = in_ready_s;
        active   = busy_r;
        underrun = underrun_r;
        d_rise   = IDLE_LEVEL;
        d_fall   = IDLE_LEVEL;
        if (!busy_r) begin
            d_rise = IDLE_LEVEL;
            d_fall = IDLE_LEVEL;
        end else if (MSB_FIRST) begin
            d_rise = sr_r[W-1];
            d_fall = sr_r[W-2];
        end else begin
            d_rise = sr_r[0];
            d_fall = sr_r[1];
        end
    end

endmodule

// File: tb/tb_ddr_serialiser.sv
// ----------------------------------------------------------------------------
// tb_ddr_serialiser
//
// Directed testbench for ddr_serialiser. It uses three instances:
//   dut_a : W=8, MSB first, idle level 0
//   dut_b : W=8, LSB first, idle level 1
//   dut_c : W=2, MSB first, idle level 0
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_ddr_serialiser;

    logic clk;
    logic rst_n;

    logic [7:0] a_in_data;
    logic       a_in_valid, a_in_ready, a_rise, a_fall, a_active, a_underrun;
    logic [7:0] b_in_data;
    logic       b_in_valid, b_in_ready, b_rise, b_fall, b_active, b_underrun;
    logic [1:0] c_in_data;
    logic       c_in_valid, c_in_ready, c_rise, c_fall, c_active, c_underrun;

    int vectors;
    int miscompares;

    ddr_serialiser #(.W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .d_rise(a_rise), .d_fall(a_fall),
        .active(a_active), .underrun(a_underrun));

    ddr_serialiser #(.W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .d_rise(b_rise), .d_fall(b_fall),
        .active(b_active), .underrun(b_underrun));

    ddr_serialiser #(.W(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .d_rise(c_rise), .d_fall(c_fall),
        .active(c_active), .underrun(c_underrun));

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset values of all three instances while rst_n is held low
    task automatic test_reset();
        #3;
        if ({a_in_ready, a_active, a_rise, a_fall, a_underrun} !== 5'b10000) begin
            $display("FAIL reset_a: got %b expected 10000", {a_in_ready, a_active, a_rise, a_fall, a_underrun});
            miscompares++;
        end
        vectors++;
        if ({b_in_ready, b_active, b_rise, b_fall, b_underrun} !== 5'b10110) begin
            $display("FAIL reset_b: got %b expected 10110", {b_in_ready, b_active, b_rise, b_fall, b_underrun});
            miscompares++;
        end
        vectors++;
        if ({c_in_ready, c_active, c_rise, c_fall, c_underrun} !== 5'b10000) begin
            $display("FAIL reset_c: got %b expected 10000", {c_in_ready, c_active, c_rise, c_fall, c_underrun});
            miscompares++;
        end
        vectors++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
    endtask

    // Single word 0xA5 MSB first, then an underrun and a return to idle
    task automatic test_single_word();
        logic [1:0] exp_p [4];
        exp_p[0] = 2'b10; exp_p[1] = 2'b10; exp_p[2] = 2'b01; exp_p[3] = 2'b01;
        a_in_valid = 1'b1;
        a_in_data  = 8'hA5;
        if (a_in_ready !== 1'b1) begin
            $display("FAIL t1_ready: got %b expected 1", a_in_ready);
            miscompares++;
        end
        vectors++;
        step();
        a_in_valid = 1'b0;
        // Word is only held at this point; the shifter loads on the next edge
        if ({a_active, a_rise, a_fall} !== 3'b000) begin
            $display("FAIL t1_latency: got %b expected 000", {a_active, a_rise, a_fall});
            miscompares++;
        end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            step();
            if ({a_active, a_rise, a_fall} !== {1'b1, exp_p[i]}) begin
                $display("FAIL t1_pair%0d: got %b expected %b", i, {a_active, a_rise, a_fall}, {1'b1, exp_p[i]});
                miscompares++;
            end
            vectors++;
        end
        step();
        if ({a_underrun, a_active, a_rise, a_fall} !== 4'b1000) begin
            $display("FAIL t1_underrun: got %b expected 1000", {a_underrun, a_active, a_rise, a_fall});
            miscompares++;
        end
        vectors++;
        step();
        if ({a_underrun, a_active} !== 2'b00) begin
            $display("FAIL t1_pulse_end: got %b expected 00", {a_underrun, a_active});
            miscompares++;
        end
        vectors++;
        step();
    endtask

    // 0xA5 then 0x3C with no idle cycle between them
    task automatic test_back_to_back();
        logic [1:0] exp_p [8];
        exp_p[0] = 2'b10; exp_p[1] = 2'b10; exp_p[2] = 2'b01; exp_p[3] = 2'b01;
        exp_p[4] = 2'b00; exp_p[5] = 2'b11; exp_p[6] = 2'b11; exp_p[7] = 2'b00;
        a_in_valid = 1'b1;
        a_in_data  = 8'hA5;
        step();
        // The held word loads on the next edge, so the buffer can take another word
        if (a_in_ready !== 1'b1) begin
            $display("FAIL t2_ready_on_load: got %b expected 1", a_in_ready);
            miscompares++;
        end
        vectors++;
        a_in_data = 8'h3C;
        step();
        a_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            if ({a_active, a_rise, a_fall, a_underrun} !== {1'b1, exp_p[i], 1'b0}) begin
                $display("FAIL t2_pair%0d: got %b expected %b", i,
                         {a_active, a_rise, a_fall, a_underrun}, {1'b1, exp_p[i], 1'b0});
                miscompares++;
            end
            vectors++;
        end
        step();
        if ({a_underrun, a_active} !== 2'b10) begin
            $display("FAIL t2_underrun: got %b expected 10", {a_underrun, a_active});
            miscompares++;
        end
        vectors++;
        step();
        step();
    endtask

    // Continuous in_valid: in_ready cadence and in-order, exactly-once delivery
    task automatic test_continuous();
        logic [7:0] words [5];
        logic [7:0] acc;
        int idx, rx, pc, und, k;
        bit hs, done;
        words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'h01; words[3] = 8'hFE; words[4] = 8'h96;
        idx = 0; rx = 0; pc = 0; und = 0; k = 0; acc = 8'h00; done = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = words[0];
        while (!done && k < 60) begin
            if (idx < 5) begin
                // From the idle start: ready on samples 0 and 1, then only on every 4th
                if (a_in_ready !== ((k < 2) || (k % 4 == 1))) begin
                    $display("FAIL t3_ready_k%0d: got %b expected %b", k, a_in_ready, ((k < 2) || (k % 4 == 1)));
                    miscompares++;
                end
                vectors++;
            end
            hs = a_in_valid && a_in_ready;
            step();
            k++;
            if (hs) begin
                idx++;
                if (idx < 5) a_in_data = words[idx];
                else a_in_valid = 1'b0;
            end
            if (a_underrun) und++;
            if (a_active) begin
                acc = {acc[5:0], a_rise, a_fall};
                pc++;
                if (pc == 4) begin
                    pc = 0;
                    if (rx >= 5) begin
                        $display("FAIL t3_extra_word: got %h expected none", acc);
                        miscompares++;
                    end else if (acc !== words[rx]) begin
                        $display("FAIL t3_word%0d: got %h expected %h", rx, acc, words[rx]);
                        miscompares++;
                    end
                    vectors++;
                    rx++;
                end
            end
            if (rx >= 5 && !a_active) done = 1'b1;
        end
        if ({idx, rx, und} !== {32'd5, 32'd5, 32'd1}) begin
            $display("FAIL t3_counts: got accepted=%0d received=%0d underruns=%0d expected 5 5 1", idx, rx, und);
            miscompares++;
        end
        vectors++;
        a_in_valid = 1'b0;
        step();
        step();
    endtask

    // LSB-first instance: 0xA5 gives the same pairs because the word is bit-symmetric
    task automatic test_lsb_first();
        logic [1:0] exp_p [4];
        exp_p[0] = 2'b10; exp_p[1] = 2'b10; exp_p[2] = 2'b01; exp_p[3] = 2'b01;
        b_in_valid = 1'b1;
        b_in_data  = 8'hA5;
        step();
        b_in_valid = 1'b0;
        if ({b_active, b_rise, b_fall} !== 3'b011) begin
            $display("FAIL t4_idle_high: got %b expected 011", {b_active, b_rise, b_fall});
            miscompares++;
        end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            step();
            if ({b_active, b_rise, b_fall} !== {1'b1, exp_p[i]}) begin
                $display("FAIL t4_pair%0d: got %b expected %b", i, {b_active, b_rise, b_fall}, {1'b1, exp_p[i]});
                miscompares++;
            end
            vectors++;
        end
        step();
        if ({b_underrun, b_active, b_rise, b_fall} !== 4'b1011) begin
            $display("FAIL t4_underrun: got %b expected 1011", {b_underrun, b_active, b_rise, b_fall});
            miscompares++;
        end
        vectors++;
        step();
    endtask

    // Reset in the middle of a word, with another word held
    task automatic test_reset_mid_word();
        logic [1:0] exp_p [4];
        exp_p[0] = 2'b00; exp_p[1] = 2'b00; exp_p[2] = 2'b11; exp_p[3] = 2'b11;
        a_in_valid = 1'b1;
        a_in_data  = 8'hA5;
        step();
        a_in_data = 8'h3C;
        step();
        a_in_valid = 1'b0;
        if ({a_rise, a_fall} !== 2'b10) begin
            $display("FAIL t5_pre_pair0: got %b expected 10", {a_rise, a_fall});
            miscompares++;
        end
        vectors++;
        step();
        if ({a_rise, a_fall} !== 2'b10) begin
            $display("FAIL t5_pre_pair1: got %b expected 10", {a_rise, a_fall});
            miscompares++;
        end
        vectors++;
        #2;
        rst_n = 1'b0;
        #1;
        if ({a_in_ready, a_active, a_rise, a_fall, a_underrun} !== 5'b10000) begin
            $display("FAIL t5_async_reset: got %b expected 10000", {a_in_ready, a_active, a_rise, a_fall, a_underrun});
            miscompares++;
        end
        vectors++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 8'h0F;
        step();
        a_in_valid = 1'b0;
        // Held 0x3C must be gone: nothing shifts until 0x0F loads
        if ({a_active, a_rise, a_fall} !== 3'b000) begin
            $display("FAIL t5_discard: got %b expected 000", {a_active, a_rise, a_fall});
            miscompares++;
        end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            step();
            if ({a_active, a_rise, a_fall} !== {1'b1, exp_p[i]}) begin
                $display("FAIL t5_pair%0d: got %b expected %b", i, {a_active, a_rise, a_fall}, {1'b1, exp_p[i]});
                miscompares++;
            end
            vectors++;
        end
        step();
        step();
    endtask

    // W=2: one word per cycle, in_ready high throughout
    task automatic test_w2_stream();
        logic [1:0] words [3];
        words[0] = 2'b10; words[1] = 2'b01; words[2] = 2'b11;
        c_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) c_in_data = words[i];
            else c_in_valid = 1'b0;
            if (c_in_ready !== 1'b1) begin
                $display("FAIL t6_ready%0d: got %b expected 1", i, c_in_ready);
                miscompares++;
            end
            vectors++;
            if (i >= 2) begin
                if ({c_active, c_rise, c_fall, c_underrun} !== {1'b1, words[i-2], 1'b0}) begin
                    $display("FAIL t6_pair%0d: got %b expected %b", i - 2,
                             {c_active, c_rise, c_fall, c_underrun}, {1'b1, words[i-2], 1'b0});
                    miscompares++;
                end
                vectors++;
            end
            step();
        end
        if ({c_underrun, c_active, c_rise, c_fall} !== 4'b1000) begin
            $display("FAIL t6_underrun: got %b expected 1000", {c_underrun, c_active, c_rise, c_fall});
            miscompares++;
        end
        vectors++;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        a_in_data = 8'h00; a_in_valid = 1'b0;
        b_in_data = 8'h00; b_in_valid = 1'b0;
        c_in_data = 2'b00; c_in_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_continuous();
        test_lsb_first();
        test_reset_mid_word();
        test_w2_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
